// File: rtl/uart_pkg.sv
// Shared UART constants for the RX buffer and the future TX side.
package uart_pkg;
    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/fifo_mem.sv
// Byte storage: synchronous write port, asynchronous read port.
module fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_RX_FIFO_DEPTH,
    parameter  int W     = UART_DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO between UART receiver and CPU.
// Define UART_RXFIFO_OVF_EN to drain while full and flag overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_RX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   resetq,
`ifdef UART_RXFIFO_OVF_EN
    input  logic                   ovf_clr,
    output logic                   ovf,
`endif
    input  logic                   rx_valid,
    input  logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_rd,
    input  logic                   rd,
    output logic                   valid,
    output logic [UART_DATA_W-1:0] data,
    output logic [AW:0]            count,
    output logic                   full
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    assign full  = (cnt_q == CNT_FULL);
    assign valid = (cnt_q != '0);
    assign count = cnt_q;
    assign push  = rx_valid & ~full;
    assign pop   = rd & valid;

`ifdef UART_RXFIFO_OVF_EN
    // Receiver is always drained; bytes arriving while full are dropped.
    assign rx_rd = rx_valid & resetq;
`else
    assign rx_rd = push & resetq;
`endif

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) wp_d = wp_q + PTR_ONE;
        if (pop)  rp_d = rp_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef UART_RXFIFO_OVF_EN
    logic ovf_q, ovf_d;

    // Set has priority over a coincident clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)         ovf_d = 1'b0;
        if (rx_valid & full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    fifo_mem #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp_q),
        .wdata (rx_data),
        .raddr (rp_q),
        .rdata (data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
`ifdef UART_RXFIFO_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rd;
    logic       rd = 1'b0;
    logic       valid;
    logic [7:0] data;
    logic [4:0] count;
    logic       full;
`ifdef UART_RXFIFO_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       ovf;
    bit         exp_ovf = 1'b0;
    bit         clr_req = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk      (clk),
        .resetq   (resetq),
`ifdef UART_RXFIFO_OVF_EN
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
`endif
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_rd    (rx_rd),
        .rd       (rd),
        .valid    (valid),
        .data     (data),
        .count    (count),
        .full     (full)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic [7:0] outq[$];
    bit         have_pend = 1'b0;
    logic [7:0] pend = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("count", 32'(count), 32'(q.size()));
        check("valid", 32'(valid), 32'(q.size() != 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        if (q.size() != 0) check("data", 32'(data), 32'(q[0]));
`ifdef UART_RXFIFO_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // Receiver model: a byte stays offered until acknowledged.
    task automatic step(input bit snd, input logic [7:0] b, input bit r);
        bit exp_rd, do_push, do_pop;
        @(negedge clk);
        resetq = 1'b1;
        if (snd && !have_pend) begin
            have_pend = 1'b1;
            pend      = b;
        end
        rx_valid = have_pend;
        rx_data  = pend;
        rd       = r;
`ifdef UART_RXFIFO_OVF_EN
        ovf_clr = clr_req;
`endif
        #1;
        do_push = have_pend && (q.size() < DEPTH);
        do_pop  = r && (q.size() > 0);
        exp_rd  = have_pend && (OVF || q.size() < DEPTH);
        check("rx_rd", 32'(rx_rd), 32'(exp_rd));
        if (do_pop) check("head", 32'(data), 32'(q[0]));
        @(posedge clk);
        #1;
        if (do_pop) outq.push_back(q.pop_front());
        if (do_push) q.push_back(pend);
`ifdef UART_RXFIFO_OVF_EN
        if (have_pend && !do_push) exp_ovf = 1'b1;
        else if (clr_req) exp_ovf = 1'b0;
        clr_req = 1'b0;
`endif
        if (exp_rd) have_pend = 1'b0;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, 8'h00, 1);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_full", 32'(full), 0);
        check("rst_rx_rd", 32'(rx_rd), 0);

        // Single byte
        step(1, 8'h41, 0);
        check("single_data", 32'(data), 32'h41);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        check("single_empty", 32'(valid), 0);

        // Burst to full, then backpressure
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
        check("burst_full", 32'(full), 1);
        step(1, 8'h10, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        check("burst_pop0", 32'(outq[outq.size()-1]), 32'h00);
        step(0, 8'h00, 0);
        check("burst_refill", 32'(count), 32'd16);
        drain();
        outq.delete();

        // Wrap: 40 incrementing bytes, occupancy kept within 0..5
        n = 0;
        for (int k = 0; k < 2000 && (n < 40 || q.size() > 0); k++) begin
            bit s, r;
            s = (n < 40) && (q.size() < 5) && ($urandom_range(1) == 1);
            r = (q.size() > 0) && ($urandom_range(2) != 0);
            step(s, 8'(8'h80 + n), r);
            if (s) n++;
        end
        check("wrap_len", 32'(outq.size()), 32'd40);
        for (int i = 0; i < outq.size(); i++)
            check("wrap_seq", 32'(outq[i]), 32'(8'h80 + i));
        outq.delete();

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) step(1, 8'(8'hA0 + i), 0);
        step(1, 8'h55, 1);
        check("simul_count", 32'(count), 32'd3);
        check("simul_tail", 32'(q[2]), 32'h55);
        drain();

        // Empty reads, then push into empty with rd held
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        step(1, 8'h7E, 1);
        check("empty_push", 32'(data), 32'h7E);
        step(0, 8'h00, 1);

        // Reset mid-burst with a byte pending at the receiver
        for (int i = 0; i < 9; i++) step(1, 8'(8'hC0 + i), 0);
        @(negedge clk);
        have_pend = 1'b1;
        pend      = 8'h33;
        rx_valid  = 1'b1;
        rx_data   = 8'h33;
        rd        = 1'b0;
        resetq    = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_full", 32'(full), 0);
        check("mid_rst_rx_rd", 32'(rx_rd), 0);
        q.delete();
`ifdef UART_RXFIFO_OVF_EN
        exp_ovf = 1'b0;
`endif
        step(0, 8'h00, 0);
        check("post_rst_data", 32'(data), 32'h33);
        drain();

`ifdef UART_RXFIFO_OVF_EN
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
        step(1, 8'h99, 0);
        check("ovf_set", 32'(ovf), 1);
        step(0, 8'h00, 0);
        clr_req = 1'b1;
        step(0, 8'h00, 0);
        check("ovf_clr", 32'(ovf), 0);
        drain();
`endif

        // Random soak
        outq.delete();
        for (int k = 0; k < 400; k++) begin
            bit s, r;
            s = ($urandom_range(3) != 0);
            r = (k < 200) ? ($urandom_range(2) == 0) : ($urandom_range(3) != 0);
`ifdef UART_RXFIFO_OVF_EN
            clr_req = ($urandom_range(7) == 0);
`endif
            step(s, 8'($urandom), r);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver, between it and the CPU I/O port.
- Drains each received byte from the receiver as soon as it is valid, issuing the receiver's read strobe, into a DEPTH-entry circular FIFO.
- Presents a first-word-fall-through interface to the CPU, so Forth KEY tolerates bursts (e.g. pasted source) at 115200 baud.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock (24 MHz)
- resetq  in  1  asynchronous active-low reset
- rx_valid  in  1  receiver holds a complete byte; stays high until acknowledged
- rx_data  in  8  receiver byte, stable while rx_valid
- rx_rd  out  1  acknowledge strobe to receiver; receiver returns to idle next cycle
- rd  in  1  CPU pop strobe, one cycle
- valid  out  1  FIFO non-empty
- data  out  8  head byte (first-word-fall-through)
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset resetq is asynchronous and active-low. On reset, write pointer, read pointer and count = 0. Outputs: valid=0, full=0, count=0, rx_rd=0. The storage array is not reset. data is don't-care while valid=0.
- Push rule, combinational:
  - rx_rd = rx_valid & ~full.
  - The push happens in the same cycle: mem[wp] <= rx_data, wp <= wp+1 modulo DEPTH.
  - rx_valid drops the cycle after rx_rd, so each byte is pushed exactly once. There is no registered acknowledge (a registered one would double-push).
- Backpressure, macro absent: while full, rx_rd stays 0 and the byte waits in the receiver. Bytes arriving on the line meanwhile are lost at the receiver. This is accepted; the FIFO never overwrites.
- Pop rule:
  - pop = rd & valid. rp <= rp+1 modulo DEPTH.
  - data = mem[rp], combinational read, so the new head is visible the cycle after the pop.
  - rd while empty is ignored: no pointer change, no underflow.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged; this is legal at any occupancy where both are permitted.
  - Push into an empty FIFO with rd asserted: the push happens, rd is ignored, count becomes 1.
  - Pop while full, with rx_valid high: full is evaluated on the current count, so there is no push that cycle. The push happens on the next cycle.
- Flags: valid = (count != 0) and full = (count == DEPTH), both derived from registered count. They are glitch-free and change the cycle after the triggering push or pop.
- Wrap-around: pointers are AW bits and wrap naturally. count carries the full/empty distinction.
- Latency: a byte acknowledged in cycle N is on data with valid=1 in cycle N+1 if the FIFO was empty.
- Reset mid-operation: all state clears immediately and buffered bytes are discarded. A receiver byte pending at reset is pushed once reset is released, if rx_valid is still high.

Optional Feature:
- Macro: UART_RXFIFO_OVF_EN.
- With the macro:
  - Adds ports ovf (out, 1) and ovf_clr (in, 1).
  - When full, rx_rd = rx_valid, so the receiver is always drained. The incoming byte is dropped: no write, no pointer change.
  - The sticky ovf flag is set the following cycle. It is cleared by an ovf_clr pulse; if clear and set happen in the same cycle, set wins. ovf resets to 0.
- Without the macro: backpressure as above, and the ports ovf and ovf_clr do not exist.

Decomposition:
- Shared package/include uart_pkg:
  - UART_DATA_W = 8.
  - Default RX FIFO depth constant, reused by a future TX FIFO.
- One natural sub-module: fifo_mem, the DEPTH x 8 storage with a synchronous write port and an asynchronous read port. It maps to iCE40 LUT RAM or logic, and the same array serves the TX side later.
- Pointer and count control stay in uart_rx_fifo.

Test Plan:
- Single byte: rx_valid with 0x41 -> rx_rd high for exactly 1 cycle; next cycle valid=1, data=0x41, count=1. rd pulse -> valid=0, count=0.
- Burst: 16 bytes 0x00..0x0F with no reads -> full=1, count=16. A 17th rx_valid (0x10) -> rx_rd stays 0. Pop one (data=0x00) -> next cycle 0x10 is pushed, count back to 16.
- Wrap: push/pop 40 bytes of an incrementing pattern interleaved, occupancy 0..5 -> output sequence identical to input, pointers wrapped twice.
- Simultaneous: count=3, push 0x55 and pop in the same cycle -> count stays 3, the old head is removed, 0x55 becomes the tail.
- Empty read: rd held for 4 cycles with the FIFO empty -> count=0, valid=0, no pointer change. A following push of 0x7E is read back correctly.
- Reset mid-burst: resetq low with count=9 -> valid=0, count=0, full=0 asynchronously. With UART_RXFIFO_OVF_EN and the FIFO full, push 0x99 -> rx_rd=1, byte dropped, ovf=1 until ovf_clr.
